// File: rtl/pwm_i2c_reg_ctrl_pkg.sv
// Shared constants for the I2C-to-register-file byte sequencer:
// FSM state encodings, pointer soft-reset value and default sizing.
package pwm_i2c_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_W_PTR   = 3'd1;
    localparam logic [2:0] ST_W_HI    = 3'd2;
    localparam logic [2:0] ST_W_LO    = 3'd3;
    localparam logic [2:0] ST_R_FETCH = 3'd4;
    localparam logic [2:0] ST_R_HI    = 3'd5;
    localparam logic [2:0] ST_R_LO    = 3'd6;

    localparam logic [7:0]  PTR_SOFT_RST = 8'd255;
    localparam int unsigned MAX_ADDR_DEF = 41;
    localparam int unsigned WIDTH_DEF    = 16;

endpackage

// File: rtl/pwm_i2c_reg_ctrl_if.sv
// Byte-level handshake between the I2C slave engine (master modport)
// and the register sequencer (slave modport).
interface pwm_i2c_reg_ctrl_if;

    logic       start_i;
    logic       rw_i;
    logic       stop_i;
    logic       rx_valid_i;
    logic [7:0] rx_byte_i;
    logic       tx_ack_i;
    logic [7:0] tx_byte_o;

    modport master (
        output start_i, rw_i, stop_i, rx_valid_i, rx_byte_i, tx_ack_i,
        input  tx_byte_o
    );

    modport slave (
        input  start_i, rw_i, stop_i, rx_valid_i, rx_byte_i, tx_ack_i,
        output tx_byte_o
    );

endinterface

// File: rtl/pwm_i2c_reg_ctrl.sv
// Turns an I2C byte stream (pointer, then MSB-first 16-bit words) into
// single-cycle register-file strobes, and streams register reads back out.
module pwm_i2c_reg_ctrl
    import pwm_i2c_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned MAX_ADDR = MAX_ADDR_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    pwm_i2c_reg_ctrl_if.slave    i2c,
    output logic                 wr_en_o,
    output logic                 rd_en_o,
    output logic [7:0]           addr_o,
    output logic [WIDTH-1:0]     wr_data_o,
    input  logic [WIDTH-1:0]     rd_data_i,
    output logic                 busy_o
);

    localparam logic [7:0] MAX_PTR = 8'(MAX_ADDR);

    logic [2:0]       state_q,   state_d;
    logic [7:0]       ptr_q,     ptr_d;
    logic [7:0]       hi_buf_q,  hi_buf_d;
    logic [7:0]       rd_buf_q,  rd_buf_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             wr_en_q,   wr_en_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;

    function automatic logic [7:0] ptr_next(input logic [7:0] p);
        if (p == MAX_PTR || p == PTR_SOFT_RST) begin
            return '0;
        end
        return p + 8'd1;
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hi_buf_d  = hi_buf_q;
        rd_buf_d  = rd_buf_q;
        tx_byte_d = tx_byte_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;

        // The pointer steps after the write strobe so addr_o shows the old pointer during it.
        if (wr_en_q) begin
            ptr_d = ptr_next(ptr_q);
        end

        if (i2c.start_i) begin
            state_d = i2c.rw_i ? ST_R_FETCH : ST_W_PTR;
        end else if (i2c.stop_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_W_PTR: begin
                    if (i2c.rx_valid_i) begin
                        ptr_d   = i2c.rx_byte_i;
                        state_d = ST_W_HI;
                    end
                end
                ST_W_HI: begin
                    if (i2c.rx_valid_i) begin
                        hi_buf_d = i2c.rx_byte_i;
                        state_d  = ST_W_LO;
                    end
                end
                ST_W_LO: begin
                    if (i2c.rx_valid_i) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = {hi_buf_q, i2c.rx_byte_i};
                        state_d   = ST_W_HI;
                    end
                end
                ST_R_FETCH: begin
                    rd_buf_d  = rd_data_i[7:0];
                    tx_byte_d = rd_data_i[WIDTH-1 -: 8];
                    state_d   = ST_R_HI;
                end
                ST_R_HI: begin
                    if (i2c.tx_ack_i) begin
                        tx_byte_d = rd_buf_q;
                        state_d   = ST_R_LO;
                    end
                end
                ST_R_LO: begin
                    if (i2c.tx_ack_i) begin
                        ptr_d   = ptr_next(ptr_q);
                        state_d = ST_R_FETCH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            hi_buf_q  <= '0;
            rd_buf_q  <= '0;
            tx_byte_q <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hi_buf_q  <= hi_buf_d;
            rd_buf_q  <= rd_buf_d;
            tx_byte_q <= tx_byte_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign i2c.tx_byte_o = tx_byte_q;
    assign wr_en_o       = wr_en_q;
    assign rd_en_o       = (state_q == ST_R_FETCH);
    assign addr_o        = ptr_q;
    assign wr_data_o     = wr_data_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_i2c_reg_ctrl.sv
// Self-checking bench: directed scenarios plus randomized transactions
// checked against a word-level model of pointer, memory and strobes.
module tb_pwm_i2c_reg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en, rd_en, busy;
    logic [7:0]  addr;
    logic [15:0] wr_data, rd_data;

    always #5 clk = ~clk;

    pwm_i2c_reg_ctrl_if bus();

    pwm_i2c_reg_ctrl #(.WIDTH(16), .MAX_ADDR(41)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .i2c      (bus),
        .wr_en_o  (wr_en),
        .rd_en_o  (rd_en),
        .addr_o   (addr),
        .wr_data_o(wr_data),
        .rd_data_i(rd_data),
        .busy_o   (busy)
    );

    // Environment register file
    logic [15:0] regs [256];
    assign rd_data = regs[addr];
    always @(posedge clk) if (wr_en) regs[addr] <= wr_data;

    int unsigned wr_pulses = 0;
    int unsigned overlap   = 0;
    always @(negedge clk) begin
        if (wr_en) wr_pulses++;
        if (wr_en && rd_en) overlap++;
    end

    // Reference model
    logic [15:0] mem_m [256];
    logic [7:0]  m_ptr;
    int unsigned exp_wr = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;

    function automatic logic [7:0] adv(input logic [7:0] p);
        int unsigned v;
        v = p;
        if (v == 41 || v == 255) return 8'd0;
        return 8'(v + 1);
    endfunction

    task automatic pulse_start(input logic rw);
        @(negedge clk); bus.start_i = 1'b1; bus.rw_i = rw;
        @(negedge clk); bus.start_i = 1'b0; bus.rw_i = 1'b0;
    endtask

    task automatic pulse_byte(input logic [7:0] b, input logic with_stop);
        @(negedge clk); bus.rx_valid_i = 1'b1; bus.rx_byte_i = b; bus.stop_i = with_stop;
        @(negedge clk); bus.rx_valid_i = 1'b0; bus.stop_i = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); bus.stop_i = 1'b1;
        @(negedge clk); bus.stop_i = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge clk); bus.tx_ack_i = 1'b1;
        @(negedge clk); bus.tx_ack_i = 1'b0;
    endtask

    task automatic set_ptr(input logic [7:0] p);
        pulse_start(1'b0);
        pulse_byte(p, 1'b0);
        m_ptr = p;
    endtask

    task automatic write_word(input logic [15:0] w);
        logic [7:0] hb, lb;
        hb = w[15:8];
        lb = w[7:0];
        pulse_byte(hb, 1'b0);
        pulse_byte(lb, 1'b0);
        checks++;
        if (wr_en !== 1'b1 || addr !== m_ptr || wr_data !== w) begin
            failures++;
            $display("FAIL write_strobe: wr_en=%b addr=%h data=%h, want 1 addr=%h data=%h",
                     wr_en, addr, wr_data, m_ptr, w);
        end
        mem_m[m_ptr] = w;
        m_ptr = adv(m_ptr);
        exp_wr++;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || addr !== m_ptr) begin
            failures++;
            $display("FAIL write_after: wr_en=%b addr=%h, want 0 addr=%h", wr_en, addr, m_ptr);
        end
    endtask

    // Entered with the DUT in the fetch cycle; leaves it in the next fetch cycle.
    task automatic read_word();
        logic [15:0] w;
        w = mem_m[m_ptr];
        checks++;
        if (rd_en !== 1'b1 || addr !== m_ptr) begin
            failures++;
            $display("FAIL read_fetch: rd_en=%b addr=%h, want 1 addr=%h", rd_en, addr, m_ptr);
        end
        @(negedge clk);
        checks++;
        if (bus.tx_byte_o !== w[15:8] || rd_en !== 1'b0) begin
            failures++;
            $display("FAIL read_hi: tx=%h rd_en=%b, want tx=%h rd_en=0", bus.tx_byte_o, rd_en, w[15:8]);
        end
        pulse_ack();
        checks++;
        if (bus.tx_byte_o !== w[7:0]) begin
            failures++;
            $display("FAIL read_lo: tx=%h, want %h", bus.tx_byte_o, w[7:0]);
        end
        pulse_ack();
        m_ptr = adv(m_ptr);
    endtask

    task automatic end_txn(input string name);
        pulse_stop();
        checks++;
        if (busy !== 1'b0 || addr !== m_ptr || wr_pulses !== exp_wr) begin
            failures++;
            $display("FAIL %s_end: busy=%b addr=%h writes=%0d, want busy=0 addr=%h writes=%0d",
                     name, busy, addr, wr_pulses, m_ptr, exp_wr);
        end
    endtask

    task automatic test_reset();
        bus.start_i = 0; bus.rw_i = 0; bus.stop_i = 0;
        bus.rx_valid_i = 0; bus.rx_byte_i = 0; bus.tx_ack_i = 0;
        for (int i = 0; i < 256; i++) begin
            regs[i]  = 16'(i * 16'h0101 + 16'h5a);
            mem_m[i] = 16'(i * 16'h0101 + 16'h5a);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_en !== 0 || rd_en !== 0 || addr !== 8'h00 || wr_data !== 16'h0 ||
            busy !== 0 || bus.tx_byte_o !== 8'h00) begin
            failures++;
            $display("FAIL reset: wr=%b rd=%b addr=%h wd=%h busy=%b tx=%h, want all zero",
                     wr_en, rd_en, addr, wr_data, busy, bus.tx_byte_o);
        end
        rst_n = 1'b1;
        m_ptr = 8'h00;
    endtask

    task automatic test_write();
        set_ptr(8'h02);
        write_word(16'h1234);
        checks++;
        if (addr !== 8'h03) begin
            failures++;
            $display("FAIL write_ptr: addr=%h, want 03", addr);
        end
        end_txn("write");
    endtask

    task automatic test_burst();
        set_ptr(8'h28);
        write_word(16'hAABB);
        write_word(16'hCCDD);
        end_txn("burst");
        checks++;
        if (regs[40] !== 16'hAABB || regs[41] !== 16'hCCDD || addr !== 8'h00) begin
            failures++;
            $display("FAIL burst_wrap: r40=%h r41=%h addr=%h, want AABB CCDD 00", regs[40], regs[41], addr);
        end
    endtask

    task automatic test_read_stream();
        regs[1] = 16'h0007; mem_m[1] = 16'h0007;
        regs[2] = 16'hFFFF; mem_m[2] = 16'hFFFF;
        set_ptr(8'h01);
        pulse_start(1'b1);
        read_word();
        read_word();
        end_txn("read_stream");
    endtask

    task automatic test_abort();
        set_ptr(8'h0A);
        pulse_byte(8'h55, 1'b0);
        end_txn("abort");
        set_ptr(8'h0B);
        pulse_byte(8'h66, 1'b0);
        pulse_byte(8'h77, 1'b1);
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || wr_pulses !== exp_wr) begin
            failures++;
            $display("FAIL abort_same_cycle: wr_en=%b busy=%b writes=%0d, want 0 0 %0d",
                     wr_en, busy, wr_pulses, exp_wr);
        end
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || addr !== 8'h0B) begin
            failures++;
            $display("FAIL abort_same_cycle_after: wr_en=%b addr=%h, want 0 0B", wr_en, addr);
        end
    endtask

    task automatic test_soft_reset();
        set_ptr(8'hFF);
        write_word(16'h0001);
        end_txn("soft_reset");
        checks++;
        if (regs[255] !== 16'h0001) begin
            failures++;
            $display("FAIL soft_reset_data: r255=%h, want 0001", regs[255]);
        end
    endtask

    task automatic test_async_reset();
        set_ptr(8'h05);
        pulse_byte(8'h11, 1'b0);
        @(negedge clk);
        bus.rx_valid_i = 1'b1; bus.rx_byte_i = 8'h22;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (wr_en !== 0 || rd_en !== 0 || addr !== 8'h00 || wr_data !== 16'h0 ||
            busy !== 0 || bus.tx_byte_o !== 8'h00) begin
            failures++;
            $display("FAIL async_reset: wr=%b rd=%b addr=%h wd=%h busy=%b tx=%h, want all zero",
                     wr_en, rd_en, addr, wr_data, busy, bus.tx_byte_o);
        end
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
        rst_n = 1'b1;
        m_ptr = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || wr_pulses !== exp_wr || addr !== 8'h00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_after: wr_en=%b writes=%0d addr=%h busy=%b, want 0 %0d 00 0",
                     wr_en, wr_pulses, exp_wr, addr, busy);
        end
    endtask

    task automatic test_random();
        int unsigned kind, n;
        logic [7:0] p;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0: p = 8'($urandom_range(36, 41));
                1: p = 8'($urandom_range(252, 255));
                default: p = 8'($urandom_range(0, 255));
            endcase
            n = $urandom_range(1, 4);
            if (kind == 0) begin
                set_ptr(p);
                for (int k = 0; k < int'(n); k++) begin
                    write_word(16'($urandom));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                end_txn("rand_write");
            end else if (kind == 1) begin
                if ($urandom_range(0, 1) == 1) set_ptr(p);
                pulse_start(1'b1);
                for (int k = 0; k < int'(n); k++) read_word();
                end_txn("rand_read");
            end else if (kind == 2) begin
                set_ptr(p);
                write_word(16'($urandom));
                pulse_byte(8'($urandom), 1'b0);
                pulse_start(1'b1);
                read_word();
                end_txn("rand_discard");
            end else begin
                set_ptr(p);
                pulse_byte(8'($urandom), 1'b0);
                if ($urandom_range(0, 1) == 1) begin
                    pulse_byte(8'($urandom), 1'b1);
                    @(negedge clk);
                    checks++;
                    if (busy !== 1'b0 || wr_pulses !== exp_wr || addr !== m_ptr) begin
                        failures++;
                        $display("FAIL rand_abort: busy=%b writes=%0d addr=%h, want 0 %0d %h",
                                 busy, wr_pulses, addr, exp_wr, m_ptr);
                    end
                end else begin
                    end_txn("rand_abort");
                end
            end
        end
        checks++;
        if (overlap !== 0) begin
            failures++;
            $display("FAIL strobe_overlap: count=%0d, want 0", overlap);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_burst();
        test_read_stream();
        test_abort();
        test_soft_reset();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
